// File: rtl/regfile_mp.sv
// regfile_mp: 2R/1W register file with a per-register pending-write
// scoreboard. Reg 0 reads as zero, reg 2 resets to SP_INIT.
// Each read port stalls in-block on a reserved register until the
// matching writeback commits it.
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding of
// din to same-cycle reads and to waiting reads).
module regfile_mp #(
  parameter int                 REG_SZ  = 64,
  parameter int                 REG_NUM = 32,
  parameter logic [REG_SZ-1:0]  SP_INIT = REG_SZ'(32'h0001_0000),
  localparam int                IW      = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_a,
  input  logic [IW-1:0]     ridx_a,
  output logic [REG_SZ-1:0] rdata_a,
  output logic              rvalid_a,
  output logic              rstall_a,
  input  logic              re_b,
  input  logic [IW-1:0]     ridx_b,
  output logic [REG_SZ-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              rstall_b,
  input  logic              we,
  input  logic [IW-1:0]     widx,
  input  logic [REG_SZ-1:0] din,
  input  logic              rsv,
  input  logic [IW-1:0]     rsv_idx,
  output logic [REG_NUM-1:0] busy
);

  typedef enum logic {S_IDLE, S_WAIT} rd_st_e;

  logic [REG_SZ-1:0]  regs_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_d;

  // Register array: writes to index 0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      regs_q[2] <= SP_INIT;
    end else if (we && widx != '0) begin
      regs_q[widx] <= din;
    end
  end

  // Scoreboard next state: commit clears, reservation sets and wins a tie.
  always_comb begin
    busy_d = busy_q;
    if (we)  busy_d[widx]    = 1'b0;
    if (rsv) busy_d[rsv_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

  logic [1:0]             re_v;
  logic [1:0][IW-1:0]     ridx_v;
  logic [1:0][REG_SZ-1:0] rdata_v;
  logic [1:0]             rvalid_v, rstall_v;

  assign re_v   = {re_b, re_a};
  assign ridx_v = {ridx_b, ridx_a};

  for (genvar p = 0; p < 2; p++) begin : g_port
    rd_st_e            st_q;
    logic [IW-1:0]     lidx_q;
    logic [REG_SZ-1:0] rdata_q;
    logic              rvalid_q, rstall_q;
    logic              wr_hit_rd, wr_hit_wait;

    // Commit to a nonzero index matching the live read / the latched index.
    assign wr_hit_rd   = we && (widx == ridx_v[p]) && (widx != '0);
    assign wr_hit_wait = we && (widx == lidx_q);

    // Read FSM: serve immediately when clean, otherwise park in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q     <= S_IDLE;
        lidx_q   <= '0;
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
        rstall_q <= 1'b0;
      end else begin
        rvalid_q <= 1'b0;
        case (st_q)
          S_IDLE: begin
            if (re_v[p]) begin
`ifdef REGFILE_BYPASS_EN
              if (wr_hit_rd) begin
                rdata_q  <= din;
                rvalid_q <= 1'b1;
              end else
`endif
              if (!busy_q[ridx_v[p]]) begin
                rdata_q  <= regs_q[ridx_v[p]];
                rvalid_q <= 1'b1;
              end else begin
                lidx_q   <= ridx_v[p];
                rstall_q <= 1'b1;
                st_q     <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
`ifdef REGFILE_BYPASS_EN
            // Forward the committing data on the same edge.
            if (wr_hit_wait) begin
              rdata_q  <= din;
              rvalid_q <= 1'b1;
              rstall_q <= 1'b0;
              st_q     <= S_IDLE;
            end
`else
            // Wait for the registered busy bit to drop, then read the array.
            if (!busy_q[lidx_q]) begin
              rdata_q  <= regs_q[lidx_q];
              rvalid_q <= 1'b1;
              rstall_q <= 1'b0;
              st_q     <= S_IDLE;
            end
`endif
          end
          default: st_q <= S_IDLE;
        endcase
      end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_hit;
    assign unused_hit = wr_hit_rd ^ wr_hit_wait;
`endif

    assign rdata_v[p]  = rdata_q;
    assign rvalid_v[p] = rvalid_q;
    assign rstall_v[p] = rstall_q;
  end

  assign rdata_a  = rdata_v[0];
  assign rdata_b  = rdata_v[1];
  assign rvalid_a = rvalid_v[0];
  assign rvalid_b = rvalid_v[1];
  assign rstall_a = rstall_v[0];
  assign rstall_b = rstall_v[1];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven reads plus hand sequences for stall,
// bypass, reservation tie and reset-in-WAIT. Read data is checked by a
// per-port scoreboard queue popped on every rvalid.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re_a = 0, re_b = 0, we = 0, rsv = 0;
  logic [4:0]  ridx_a = 0, ridx_b = 0, widx = 0, rsv_idx = 0;
  logic [63:0] din = 0;
  logic [63:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, rstall_a, rstall_b;
  logic [31:0] busy;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .re_a(re_a), .ridx_a(ridx_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a), .rstall_a(rstall_a),
    .re_b(re_b), .ridx_b(ridx_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b), .rstall_b(rstall_b),
    .we(we), .widx(widx), .din(din), .rsv(rsv), .rsv_idx(rsv_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] fill_val(input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(k) * 64'h0101_0001);
  endfunction

  // Scoreboard: every rvalid must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid_a) begin
        if (qa.size() == 0) chk("rvalid_a unexpected", 1, 0);
        else chk("rdata_a", rdata_a, qa.pop_front());
      end
      if (rvalid_b) begin
        if (qb.size() == 0) chk("rvalid_b unexpected", 1, 0);
        else chk("rdata_b", rdata_b, qb.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [63:0] d);
    we = 1; widx = idx; din = d;
    cyc();
    we = 0;
  endtask

  task automatic rd(input bit port, input logic [4:0] idx, input logic [63:0] exp);
    if (!port) begin re_a = 1; ridx_a = idx; qa.push_back(exp); end
    else       begin re_b = 1; ridx_b = idx; qb.push_back(exp); end
    cyc();
    re_a = 0; re_b = 0;
  endtask

  typedef struct {
    bit          port;
    logic [4:0]  idx;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ilist[10];
    ilist = '{1, 31, 0, 3, 2, 16, 30, 8, 5, 17};
    for (int i = 0; i < 10; i++) begin
      vecs[i].port = i[0];
      vecs[i].idx  = 5'(ilist[i]);
      vecs[i].exp  = (ilist[i] == 0) ? 64'h0 : fill_val(ilist[i]);
    end

    // Reset state
    #3;
    chk("reset busy", busy, 0);
    chk("reset rdata_a", rdata_a, 0);
    chk("reset rdata_b", rdata_b, 0);
    chk("reset rvalid", {rvalid_a, rvalid_b}, 0);
    chk("reset rstall", {rstall_a, rstall_b}, 0);
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // SP and zero-initialised register on both ports at once
    re_a = 1; ridx_a = 2; re_b = 1; ridx_b = 5;
    qa.push_back(64'h1_0000); qb.push_back(64'h0);
    cyc();
    re_a = 0; re_b = 0;
    chk("rvalid_a latency", rvalid_a, 1);
    chk("rvalid_b latency", rvalid_b, 1);
    cyc();
    chk("rvalid_a pulse", rvalid_a, 0);

    // Writes to reg 0 are dropped
    wr(0, 64'hDEAD);
    rd(0, 0, 64'h0);
    chk("busy0", busy[0], 0);

    // Table-driven reads after preloading every register
    for (int k = 1; k < 32; k++) wr(5'(k), fill_val(k));
    for (int i = 0; i < 10; i++) rd(vecs[i].port, vecs[i].idx, vecs[i].exp);
    cyc();

    // Read in the same cycle as a reservation sees the old state
    rsv = 1; rsv_idx = 20; re_a = 1; ridx_a = 20; qa.push_back(fill_val(20));
    cyc();
    rsv = 0; re_a = 0;
    chk("rsv-same-cycle no stall", rstall_a, 0);
    chk("busy20 set", busy[20], 1);
    wr(20, 64'h2020);
    chk("busy20 cleared", busy[20], 0);

    // Stall on a reserved register, released by writeback
    rsv = 1; rsv_idx = 7; cyc(); rsv = 0;
    chk("busy7 set", busy[7], 1);
    re_a = 1; ridx_a = 7; cyc(); re_a = 0;
    chk("stall7 rstall", rstall_a, 1);
    chk("stall7 no rvalid", rvalid_a, 0);
    cyc(); cyc();
    chk("stall7 held", rstall_a, 1);
    we = 1; widx = 7; din = 64'h1234; qa.push_back(64'h1234);
    cyc(); we = 0;
    chk("release N+1", rvalid_a, BYP);
    cyc();
    chk("release N+2", rvalid_a, !BYP);
    chk("busy7 clear", busy[7], 0);
    chk("stall7 rstall clear", rstall_a, 0);

    // Same-cycle write and read of a non-busy register
    wr(9, 64'h55);
    we = 1; widx = 9; din = 64'hAA; re_b = 1; ridx_b = 9;
    qb.push_back(BYP ? 64'hAA : 64'h55);
    cyc();
    we = 0; re_b = 0;
    rd(1, 9, 64'hAA);

    // Reservation and commit on the same edge: reservation wins
    rsv = 1; rsv_idx = 4; we = 1; widx = 4; din = 64'h44;
    cyc();
    rsv = 0; we = 0;
    chk("busy4 after tie", busy[4], 1);
    re_a = 1; ridx_a = 4; cyc(); re_a = 0;
    chk("stall4", rstall_a, 1);
    cyc(); cyc();
    chk("stall4 held", rstall_a, 1);
    qa.push_back(64'h99);
    wr(4, 64'h99);
    cyc(); cyc();
    chk("busy4 clear", busy[4], 0);
    chk("stall4 clear", rstall_a, 0);

    // Both ports waiting on reg 12, then reset mid-WAIT
    wr(12, 64'h77);
    rsv = 1; rsv_idx = 12; cyc(); rsv = 0;
    re_a = 1; ridx_a = 12; re_b = 1; ridx_b = 12;
    cyc();
    re_a = 0; re_b = 0;
    chk("wait12 rstall_a", rstall_a, 1);
    chk("wait12 rstall_b", rstall_b, 1);
    cyc();
    rst_n = 0;
    #2;
    chk("rst mid-wait rstall", {rstall_a, rstall_b}, 0);
    chk("rst mid-wait busy", busy, 0);
    chk("rst mid-wait rvalid", {rvalid_a, rvalid_b}, 0);
    cyc(); cyc();
    rst_n = 1;
    cyc(); cyc();
    chk("post-rst no rvalid", {rvalid_a, rvalid_b}, 0);
    re_a = 1; ridx_a = 12; re_b = 1; ridx_b = 2;
    qa.push_back(64'h0); qb.push_back(64'h1_0000);
    cyc();
    re_a = 0; re_b = 0;
    cyc(); cyc(); cyc();

    chk("qa drained", 64'(qa.size()), 0);
    chk("qb drained", 64'(qb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
